// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle instruction fetch controller driving PC, memory read port and decode handshake
module fetch_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_q,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_d,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data,
    output logic [31:0]       ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              busy,
    output logic              fault
);
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, LOAD, HOLD, FAULT} state_t;

    state_t            r_state, w_state_nx;
    logic              r_flush, w_flush_nx;
    logic [ADDR_W-1:0] r_tgt, w_tgt_nx;
    logic [3:0]        r_cnt, w_cnt_nx;
    logic              r_pc_inc, w_pc_inc_nx;
    logic              r_pc_load, w_pc_load_nx;
    logic [ADDR_W-1:0] r_pc_d, w_pc_d_nx;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nx;
    logic [31:0]       r_ir, w_ir_nx;
    logic              w_br_bad;

    assign w_br_bad = br_valid & (|br_target[1:0]);
    assign pc_inc   = r_pc_inc;
    assign pc_load  = r_pc_load;
    assign pc_d     = r_pc_d;
    assign mem_addr = r_mem_addr;
    assign ir_out   = r_ir;
    assign mem_rd   = (r_state == WAIT);
    assign ir_valid = (r_state == HOLD);
    assign busy     = (r_state != IDLE);
    assign fault    = (r_state == FAULT);

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    // Next-state and next-value decode; ADDR holds off sampling pc_q while a pc_load pulse is still in flight
    always_comb begin
        w_state_nx    = r_state;
        w_flush_nx    = r_flush;
        w_tgt_nx      = r_tgt;
        w_cnt_nx      = r_cnt;
        w_pc_inc_nx   = 1'b0;
        w_pc_load_nx  = 1'b0;
        w_pc_d_nx     = r_pc_d;
        w_mem_addr_nx = r_mem_addr;
        w_ir_nx       = r_ir;
        case (r_state)
            IDLE: w_state_nx = run ? ADDR : IDLE;
            ADDR: begin
                if (w_br_bad) begin
                    w_state_nx = FAULT;
                end else if (br_valid) begin
                    w_pc_load_nx = 1'b1;
                    w_pc_d_nx    = br_target;
                end else if (!r_pc_load) begin
                    w_mem_addr_nx = pc_q;
                    w_cnt_nx      = 4'd0;
                    w_state_nx    = (|pc_q[1:0]) ? FAULT : WAIT;
                end
            end
            WAIT: begin
                if (w_br_bad) begin
                    w_state_nx = FAULT;
                end else begin
                    if (br_valid) begin
                        w_flush_nx = 1'b1;
                        w_tgt_nx   = br_target;
                    end
                    if (mem_ack) begin
                        w_state_nx = LOAD;
                        w_ir_nx    = (r_flush | br_valid) ? r_ir : mem_data;
                    end else if (r_cnt == 4'(TIMEOUT - 1)) begin
                        w_state_nx = FAULT;
                    end else begin
                        w_cnt_nx = (r_cnt == 4'hf) ? r_cnt : r_cnt + 4'd1;
                    end
                end
            end
            LOAD: begin
                if (w_br_bad) begin
                    w_state_nx = FAULT;
                end else if (r_flush | br_valid) begin
                    w_pc_load_nx = 1'b1;
                    w_pc_d_nx    = br_valid ? br_target : r_tgt;
                    w_flush_nx   = 1'b0;
                    w_state_nx   = ADDR;
                end else begin
                    w_pc_inc_nx = 1'b1;
                    w_state_nx  = HOLD;
                end
            end
            HOLD: begin
                if (w_br_bad) begin
                    w_state_nx = FAULT;
                end else if (br_valid) begin
                    w_pc_load_nx = 1'b1;
                    w_pc_d_nx    = br_target;
                    w_state_nx   = ADDR;
                end else if (ir_ready) begin
                    w_state_nx = run ? ADDR : IDLE;
                end
            end
            default: w_state_nx = FAULT;
        endcase
    end

    // Datapath and pulse registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_flush    <= 1'b0;
            r_tgt      <= '0;
            r_cnt      <= 4'd0;
            r_pc_inc   <= 1'b0;
            r_pc_load  <= 1'b0;
            r_pc_d     <= '0;
            r_mem_addr <= '0;
            r_ir       <= '0;
        end else begin
            r_flush    <= w_flush_nx;
            r_tgt      <= w_tgt_nx;
            r_cnt      <= w_cnt_nx;
            r_pc_inc   <= w_pc_inc_nx;
            r_pc_load  <= w_pc_load_nx;
            r_pc_d     <= w_pc_d_nx;
            r_mem_addr <= w_mem_addr_nx;
            r_ir       <= w_ir_nx;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for the fetch controller with a PC register model
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        pc_inc, pc_load;
    logic [31:0] pc_d;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        busy, fault;
    logic        pc_wr = 1'b0;
    logic [31:0] pc_wval = 32'h0;
    int          checks = 0;
    int          errors = 0;
    int          n_inc = 0;

    fetch_sequencer dut (
        .clk(clk), .clr_n(clr_n), .run(run), .pc_q(pc),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_d(pc_d),
        .br_valid(br_valid), .br_target(br_target),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
        .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    // PC register: branch load has priority over increment
    always @(posedge clk) begin
        if (pc_wr) pc <= pc_wval;
        else if (pc_load) pc <= pc_d;
        else if (pc_inc) pc <= pc + 32'd4;
    end

    // Pulse counting and mutual-exclusion watch
    always @(negedge clk) begin
        if (pc_inc) n_inc++;
        if (pc_inc && pc_load) begin
            errors++;
            $display("FAIL excl: pc_inc=%0b pc_load=%0b both high", pc_inc, pc_load);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [31:0] start_pc);
        clr_n = 1'b0; run = 1'b0; br_valid = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
        pc_wr = 1'b1; pc_wval = start_pc;
        tick();
        tick();
        pc_wr = 1'b0;
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(32'h0);
        checks++;
        if ({busy, fault, mem_rd, ir_valid, pc_inc, pc_load} !== 6'b0 || mem_addr !== 32'h0 || ir_out !== 32'h0 || pc_d !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%0b fault=%0b rd=%0b iv=%0b inc=%0b ld=%0b addr=%h ir=%h pcd=%h, want all 0",
                     busy, fault, mem_rd, ir_valid, pc_inc, pc_load, mem_addr, ir_out, pc_d);
        end
    endtask

    task automatic test_fetch();
        run = 1'b1; ir_ready = 1'b1; mem_data = 32'hA5A5_0001;
        tick();
        checks++;
        if (busy !== 1'b1 || mem_rd !== 1'b0) begin
            errors++; $display("FAIL addr_state: busy=%0b rd=%0b, want 1 0", busy, mem_rd);
        end
        tick();
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL wait_rd: rd=%0b addr=%h, want 1 0", mem_rd, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (ir_out !== 32'hA5A5_0001 || mem_rd !== 1'b0 || ir_valid !== 1'b0) begin
            errors++; $display("FAIL load: ir=%h rd=%0b iv=%0b, want a5a50001 0 0", ir_out, mem_rd, ir_valid);
        end
        tick();
        checks++;
        if (ir_valid !== 1'b1 || pc_inc !== 1'b1) begin
            errors++; $display("FAIL hold: iv=%0b inc=%0b, want 1 1", ir_valid, pc_inc);
        end
        tick();
        checks++;
        if (ir_valid !== 1'b0 || pc_inc !== 1'b0 || pc !== 32'h4) begin
            errors++; $display("FAIL accept: iv=%0b inc=%0b pc=%h, want 0 0 4", ir_valid, pc_inc, pc);
        end
    endtask

    task automatic test_stall();
        tick();
        checks++;
        if (mem_addr !== 32'h4) begin
            errors++; $display("FAIL addr2: addr=%h, want 4", mem_addr);
        end
        mem_ack = 1'b1; mem_data = 32'h1234_5678; ir_ready = 1'b0;
        tick();
        mem_ack = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ir_valid !== 1'b1 || ir_out !== 32'h1234_5678 || mem_rd !== 1'b0 || pc_inc !== 1'b0) begin
                errors++; $display("FAIL stall%0d: iv=%0b ir=%h rd=%0b inc=%0b, want 1 12345678 0 0", i, ir_valid, ir_out, mem_rd, pc_inc);
            end
        end
        ir_ready = 1'b1;
        tick();
        checks++;
        if (ir_valid !== 1'b0 || pc !== 32'h8) begin
            errors++; $display("FAIL stall_accept: iv=%0b pc=%h, want 0 8", ir_valid, pc);
        end
    endtask

    task automatic test_branch_wait();
        tick();
        br_valid = 1'b1; br_target = 32'h100; mem_data = 32'hDEAD_BEEF;
        tick();
        br_valid = 1'b0;
        tick();
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (ir_out !== 32'h1234_5678) begin
            errors++; $display("FAIL flush_discard: ir=%h, want 12345678", ir_out);
        end
        tick();
        checks++;
        if (pc_load !== 1'b1 || pc_d !== 32'h100 || pc_inc !== 1'b0 || ir_valid !== 1'b0) begin
            errors++; $display("FAIL flush_load: ld=%0b pcd=%h inc=%0b iv=%0b, want 1 100 0 0", pc_load, pc_d, pc_inc, ir_valid);
        end
        tick();
        tick();
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h100 || n_inc !== 2) begin
            errors++; $display("FAIL flush_refetch: rd=%0b addr=%h incs=%0d, want 1 100 2", mem_rd, mem_addr, n_inc);
        end
    endtask

    task automatic test_branch_load();
        mem_ack = 1'b1; mem_data = 32'h0BAD_0BAD;
        tick();
        mem_ack = 1'b0;
        br_valid = 1'b1; br_target = 32'h200;
        tick();
        br_valid = 1'b0;
        checks++;
        if (pc_inc !== 1'b0 || pc_load !== 1'b1 || pc_d !== 32'h200 || ir_valid !== 1'b0) begin
            errors++; $display("FAIL br_load: inc=%0b ld=%0b pcd=%h iv=%0b, want 0 1 200 0", pc_inc, pc_load, pc_d, ir_valid);
        end
        tick();
        tick();
        checks++;
        if (mem_addr !== 32'h200 || mem_rd !== 1'b1 || ir_valid !== 1'b0) begin
            errors++; $display("FAIL br_refetch: addr=%h rd=%0b iv=%0b, want 200 1 0", mem_addr, mem_rd, ir_valid);
        end
    endtask

    task automatic test_timeout();
        repeat (14) tick();
        checks++;
        if (fault !== 1'b0 || mem_rd !== 1'b1) begin
            errors++; $display("FAIL pre_timeout: fault=%0b rd=%0b, want 0 1", fault, mem_rd);
        end
        tick();
        checks++;
        if (fault !== 1'b1 || mem_rd !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout: fault=%0b rd=%0b busy=%0b, want 1 0 1", fault, mem_rd, busy);
        end
        mem_ack = 1'b1; br_valid = 1'b1; br_target = 32'h300;
        repeat (3) tick();
        mem_ack = 1'b0; br_valid = 1'b0;
        checks++;
        if (fault !== 1'b1 || mem_rd !== 1'b0 || ir_valid !== 1'b0 || pc_load !== 1'b0) begin
            errors++; $display("FAIL fault_sticky: fault=%0b rd=%0b iv=%0b ld=%0b, want 1 0 0 0", fault, mem_rd, ir_valid, pc_load);
        end
    endtask

    task automatic test_misaligned();
        apply_reset(32'h6);
        run = 1'b1;
        tick();
        tick();
        checks++;
        if (fault !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h6) begin
            errors++; $display("FAIL mis_pc: fault=%0b rd=%0b addr=%h, want 1 0 6", fault, mem_rd, mem_addr);
        end
        apply_reset(32'h0);
        run = 1'b1;
        tick();
        tick();
        br_valid = 1'b1; br_target = 32'h102;
        tick();
        br_valid = 1'b0;
        tick();
        checks++;
        if (fault !== 1'b1 || pc_load !== 1'b0 || mem_rd !== 1'b0 || pc !== 32'h0) begin
            errors++; $display("FAIL mis_br: fault=%0b ld=%0b rd=%0b pc=%h, want 1 0 0 0", fault, pc_load, mem_rd, pc);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset(32'h0);
        run = 1'b1;
        tick();
        tick();
        checks++;
        if (mem_rd !== 1'b1) begin
            errors++; $display("FAIL mid_wait_rd: rd=%0b, want 1", mem_rd);
        end
        #1 clr_n = 1'b0;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || busy !== 1'b0 || fault !== 1'b0 || pc_inc !== 1'b0) begin
            errors++; $display("FAIL async_reset: rd=%0b busy=%0b fault=%0b inc=%0b, want 0 0 0 0", mem_rd, busy, fault, pc_inc);
        end
        tick();
        clr_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_branch_wait();
        test_branch_load();
        test_timeout();
        test_misaligned();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
